lvds_train_ctrl: RTL

Training sequencer for a bank of LANES lvds_rx receivers, all clocked on the same clkdiv.
- Waits for IDELAYCTRL ready, then trains one lane at a time: pulses that lane's reset, enables its bit-alignment engine, and waits for a stable bitslip_done.
- Retries a lane on timeout; marks lanes that exhaust their retries as failed.
- Reports overall done/fail and watches trained lanes for loss of lock.

---
 rtl/lvds_train_ctrl_pkg.sv | 22 ++
 rtl/lvds_train_ctrl_lane_watch.sv | 44 ++++
 rtl/lvds_train_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lvds_train_ctrl_pkg.sv
// Shared types and width helpers for the lvds_rx training sequencer.
package lvds_pkg;

  localparam int TIMEOUT_CYC_DEF = 65535;
  localparam int STABLE_CYC_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_LANE_RST,
    S_ALIGN,
    S_NEXT,
    S_DONE,
    S_FAIL
  } train_state_t;

  // Counter width able to hold 0..limit-1, never narrower than one bit.
  function automatic int cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/lvds_train_ctrl_lane_watch.sv
// Per-attempt watchdog: timeout and stable-done counters for the lane under
// training. Counters sit at zero whenever en is low, so each attempt starts clean.
module lvds_lane_watch
  import lvds_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int STABLE_CYC  = STABLE_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic done_in,
  output logic success,
  output logic timeout
);

  localparam int TW = cnt_w(TIMEOUT_CYC);
  localparam int SW = cnt_w(STABLE_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYC - 1);

  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stable_cnt;

  // Saturating attempt timer and consecutive-high counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt    <= '0;
      stable_cnt <= '0;
    end else if (!en) begin
      tmo_cnt    <= '0;
      stable_cnt <= '0;
    end else begin
      if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;
      if (!done_in)                    stable_cnt <= '0;
      else if (stable_cnt != STB_LAST) stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Success needs the current cycle high too; the FSM gives it priority.
  assign success = en && done_in && (stable_cnt == STB_LAST);
  assign timeout = en && (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/lvds_train_ctrl.sv
// Trains a bank of lvds_rx lanes one at a time: reset pulse, bit-align enable,
// wait for stable bitslip_done, retry on timeout, then watch for loss of lock.
module lvds_train_ctrl
  import lvds_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int RST_CYC     = 16,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int STABLE_CYC  = STABLE_CYC_DEF,
  parameter int MAX_RETRY   = 3,
  localparam int LW         = cnt_w(LANES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             idelayctrl_rdy,
  input  logic [LANES-1:0] lane_done,
  output logic [LANES-1:0] lane_reset,
  output logic [LANES-1:0] lane_align_en,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [LANES-1:0] fail_lanes,
  output logic             lock_lost,
  output logic [LW-1:0]    cur_lane
);

  localparam int RW = cnt_w(RST_CYC);
  localparam int YW = cnt_w(MAX_RETRY + 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYC - 1);
  localparam logic [YW-1:0] RETRY_MAX = YW'(MAX_RETRY);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  train_state_t  state;
  logic [RW-1:0] rst_cnt;
  logic [YW-1:0] retry;
  logic          sel_done, att_ok, att_tmo, abort;

  assign sel_done = lane_done[cur_lane];
  // Losing IDELAYCTRL ready while a lane is in flight invalidates all results.
  assign abort    = !idelayctrl_rdy &&
                    (state inside {S_LANE_RST, S_ALIGN, S_NEXT});

  lvds_lane_watch #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .STABLE_CYC  (STABLE_CYC)
  ) u_watch (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == S_ALIGN),
    .done_in (sel_done),
    .success (att_ok),
    .timeout (att_tmo)
  );

  // Training sequencer with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      lane_reset    <= '1;
      lane_align_en <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_lanes    <= '0;
      lock_lost     <= 1'b0;
      cur_lane      <= '0;
      retry         <= '0;
      rst_cnt       <= '0;
    end else if (abort) begin
      state         <= S_WAIT_RDY;
      lane_reset    <= '1;
      lane_align_en <= '0;
      fail_lanes    <= '0;
      cur_lane      <= '0;
      retry         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          // All trained lanes must keep done high; no automatic retrain.
          if (state == S_DONE && (!idelayctrl_rdy || !(&lane_done)))
            lock_lost <= 1'b1;
          if (start) begin
            state         <= S_WAIT_RDY;
            busy          <= 1'b1;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_lanes    <= '0;
            lock_lost     <= 1'b0;
            cur_lane      <= '0;
            retry         <= '0;
            lane_reset    <= '1;
            lane_align_en <= '0;
          end
        end
        S_WAIT_RDY: begin
          if (idelayctrl_rdy) begin
            state   <= S_LANE_RST;
            rst_cnt <= RST_LAST;
          end
        end
        S_LANE_RST: begin
          lane_reset[cur_lane] <= 1'b1;
          if (rst_cnt == '0) begin
            lane_reset[cur_lane]    <= 1'b0;
            lane_align_en[cur_lane] <= 1'b1;
            state                   <= S_ALIGN;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        S_ALIGN: begin
          if (att_ok) begin
            state <= S_NEXT;
          end else if (att_tmo) begin
            lane_align_en[cur_lane] <= 1'b0;
            lane_reset[cur_lane]    <= 1'b1;
            if (retry < RETRY_MAX) begin
              retry   <= retry + 1'b1;
              rst_cnt <= RST_LAST;
              state   <= S_LANE_RST;
            end else begin
              fail_lanes[cur_lane] <= 1'b1;
              state                <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (cur_lane == LANE_LAST) begin
            busy <= 1'b0;
            if (|fail_lanes) begin
              state <= S_FAIL;
              fail  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            cur_lane <= cur_lane + 1'b1;
            retry    <= '0;
            rst_cnt  <= RST_LAST;
            state    <= S_LANE_RST;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
